// File: rtl/fir_pkg.sv
// FIR filter shared definitions.
// Default geometry and accumulator sizing.
package fir_pkg;

  localparam int NTAPS_DEF  = 37;
  localparam int DWIDTH_DEF = 15;
  localparam int CWIDTH_DEF = 11;

  function automatic int acc_width(
    input int dw,
    input int cw,
    input int nt
  );
    return dw + cw + $clog2(nt);
  endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// Balanced pairwise combinational reduction.
// One level per recursion; odd leftover passes through.
module fir_adder_tree #(
  parameter int N = 37,
  parameter int W = 32
) (
  input  logic [W-1:0] i_ops [N],
  output logic [W-1:0] o_sum
);

  if (N == 1) begin : g_leaf
    assign o_sum = i_ops[0];
  end else begin : g_lvl
    localparam int M = (N + 1) / 2;

    logic [W-1:0] w_nxt [M];

    for (genvar i = 0; i < M; i++) begin : g_pair
      if (2 * i + 1 < N) begin : g_add
        assign w_nxt[i] = i_ops[2*i] + i_ops[2*i+1];
      end else begin : g_pass
        assign w_nxt[i] = i_ops[2*i];
      end
    end

    fir_adder_tree #(
      .N(M),
      .W(W)
    ) u_next (
      .i_ops(w_nxt),
      .o_sum(o_sum)
    );
  end

endmodule

// File: rtl/fir.sv
// Two-stage unsigned FIR: registered products,
// then registered adder-tree sum.
module fir
  import fir_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int CWIDTH = CWIDTH_DEF,
  parameter int NTAPS  = NTAPS_DEF
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EN,
  input  logic [DWIDTH-1:0]        din   [NTAPS],
  input  logic [CWIDTH-1:0]        coeff [NTAPS],
  output logic [DWIDTH+CWIDTH-1:0] dout
);

  localparam int PW = DWIDTH + CWIDTH;
  localparam int AW = acc_width(DWIDTH, CWIDTH, NTAPS);

  logic [PW-1:0] r_prod [NTAPS];
  logic [AW-1:0] w_ops  [NTAPS];
  logic [AW-1:0] w_sum;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < NTAPS; k++) begin
        r_prod[k] <= '0;
      end
    end else if (EN) begin
      for (int k = 0; k < NTAPS; k++) begin
        r_prod[k] <= PW'(din[k]) * PW'(coeff[k]);
      end
    end
  end

  for (genvar k = 0; k < NTAPS; k++) begin : g_ext
    assign w_ops[k] = AW'(r_prod[k]);
  end

  fir_adder_tree #(
    .N(NTAPS),
    .W(AW)
  ) u_tree (
    .i_ops(w_ops),
    .o_sum(w_sum)
  );

  // Modular result: the carry bits above PW are dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dout <= '0;
    end else if (EN) begin
      dout <= PW'(w_sum);
    end
  end

endmodule

// File: tb/tb_fir.sv
// Directed + random bench for fir with a
// queue-based reference pipeline.
module tb_fir;

  localparam int DW = 15;
  localparam int CW = 11;
  localparam int NT = 37;
  localparam int PW = DW + CW;

  localparam int unsigned CSET [NT] = '{
    144, 115, 158, 207, 263, 325, 392, 462,
    535, 609, 682, 752, 817, 876, 926, 968,
    998, 1016, 1023, 1016, 998, 968, 926,
    876, 817, 752, 682, 609, 535, 462, 392,
    325, 263, 207, 158, 115, 144
  };

  logic          CLK;
  logic          RST;
  logic          EN;
  logic [DW-1:0] din   [NT];
  logic [CW-1:0] coeff [NT];
  logic [PW-1:0] dout;

  logic [PW-1:0] sb [$];
  logic [PW-1:0] m_dout;
  int            n_chk;
  int            n_pass;

  fir #(
    .DWIDTH(DW),
    .CWIDTH(CW),
    .NTAPS(NT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .EN(EN),
    .din(din),
    .coeff(coeff),
    .dout(dout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [PW-1:0] ref_sum();
    longint unsigned s;
    s = 0;
    for (int k = 0; k < NT; k++) begin
      s += longint'(din[k]) * longint'(coeff[k]);
    end
    return PW'(s);
  endfunction

  task automatic chk(
    input string         tag,
    input logic [PW-1:0] got,
    input logic [PW-1:0] exp
  );
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0d exp=%0d",
                tag, got, exp);
  endtask

  task automatic step(
    input logic  en,
    input logic  rst,
    input string tag
  );
    logic [PW-1:0] s;
    RST = rst;
    EN  = en;
    s = ref_sum();
    @(posedge CLK);
    if (rst) begin
      sb.delete();
      sb.push_back('0);
      m_dout = '0;
    end else if (en) begin
      m_dout = sb.pop_front();
      sb.push_back(s);
    end
    #1;
    chk(tag, dout, m_dout);
  endtask

  task automatic set_din(input int v);
    for (int k = 0; k < NT; k++) din[k] = DW'(v);
  endtask

  task automatic set_cset();
    for (int k = 0; k < NT; k++)
      coeff[k] = CW'(CSET[k]);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    m_dout = '0;
    sb.push_back('0);
    RST = 1'b1;
    EN  = 1'b0;
    set_cset();
    for (int k = 0; k < NT; k++)
      din[k] = DW'($urandom);

    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, "reset_model");
      chk("reset_zero", dout, '0);
      for (int k = 0; k < NT; k++)
        din[k] = DW'($urandom);
    end

    set_din(0);
    din[NT-1] = 1;
    step(1'b1, 1'b0, "imp_e1");
    chk("imp_e1_zero", dout, '0);
    step(1'b1, 1'b0, "imp_e2");
    chk("impulse", dout, PW'(144));

    set_din(1);
    step(1'b1, 1'b0, "dc_e1");
    step(1'b1, 1'b0, "dc_e2");
    chk("dc", dout, PW'(21513));

    set_din(0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, "hold_model");
      chk("hold", dout, PW'(21513));
    end
    step(1'b1, 1'b0, "resume_e1");
    chk("resume_e1", dout, PW'(21513));
    step(1'b1, 1'b0, "resume_e2");
    chk("resume_e2", dout, '0);

    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < NT; k++) begin
        din[k]   = DW'($urandom);
        coeff[k] = CW'($urandom);
      end
      step(1'($urandom_range(0, 1)), 1'b0,
           "random");
    end

    set_din(32767);
    for (int k = 0; k < NT; k++)
      coeff[k] = CW'(2047);
    step(1'b1, 1'b0, "wrap_e1");
    step(1'b1, 1'b0, "wrap_e2");
    chk("wrap", dout, PW'(65820709));

    set_cset();
    set_din(0);
    din[NT-1] = 1;
    step(1'b1, 1'b0, "mid_e1");
    step(1'b1, 1'b0, "mid_e2");
    chk("mid_run", dout, PW'(144));
    step(1'b1, 1'b1, "mid_rst");
    chk("mid_rst", dout, '0);
    step(1'b1, 1'b0, "mid_rel1");
    chk("mid_rel1", dout, '0);
    step(1'b1, 1'b0, "mid_rel2");
    chk("mid_rel2", dout, PW'(144));

    $display("%0d/%0d checks passed",
             n_pass, n_chk);
    $finish;
  end

endmodule
